// File: rtl/issue_ctrl.sv
// Decode-stage issue controller: load scoreboard, loads-in-flight limit, RAW/WAW stall
// and multi-cycle IF/ID flush sequencing after an EX redirect.
module issue_ctrl #(
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2,
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [4:0]    id_rs1_addr_i,
    input  logic [4:0]    id_rs2_addr_i,
    input  logic [4:0]    id_rd_addr_i,
    input  logic          id_uses_rs1_i,
    input  logic          id_uses_rs2_i,
    input  logic          id_reg_write_i,
    input  logic          id_mem_to_reg_i,
    input  logic          ex_ready_i,
    input  logic          redirect_i,
    input  logic          wb_valid_i,
    input  logic [4:0]    wb_rd_addr_i,
    output logic          issue_o,
    output logic          id_stall_o,
    output logic          id_flush_o,
    output logic [31:0]   busy_o,
    output logic [CW-1:0] pending_cnt_o
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] pending_q, pending_d;

    logic        wb_clear_s;
    logic [31:0] wb_mask_s;
    logic [31:0] busy_eff_s;
    logic [31:0] rd_onehot_s;
    logic        rd_nz_s;
    logic        hazard_s;
    logic        tracked_s;
    logic        full_s;
    logic        inc_s;
    logic        issue_s;
    logic        stall_s;
    logic        flush_s;

    // Hazard and capacity evaluation; a completing writeback releases its register this cycle
    always_comb begin
        wb_clear_s  = wb_valid_i & busy_q[wb_rd_addr_i];
        wb_mask_s   = wb_clear_s ? (32'd1 << wb_rd_addr_i) : 32'd0;
        busy_eff_s  = busy_q & ~wb_mask_s;
        rd_onehot_s = 32'd1 << id_rd_addr_i;
        rd_nz_s     = (id_rd_addr_i != 5'd0);
        hazard_s    = id_valid_i & ((id_uses_rs1_i & busy_eff_s[id_rs1_addr_i])
                                  | (id_uses_rs2_i & busy_eff_s[id_rs2_addr_i])
                                  | (id_reg_write_i & rd_nz_s & busy_eff_s[id_rd_addr_i]));
        tracked_s   = id_mem_to_reg_i & id_reg_write_i & rd_nz_s;
        full_s      = tracked_s & ((pending_q - CW'(wb_clear_s)) == CW'(MAX_PENDING));
    end

    // Issue/flush FSM next state and handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue_s = 1'b0;
        stall_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue_s = id_valid_i & ~hazard_s & ~full_s & ex_ready_i & ~redirect_i;
                stall_s = id_valid_i & ~issue_s & ~redirect_i;
                flush_s = redirect_i;
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                if (cnt_q <= FW'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - FW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        // cnt counts remaining flush cycles after the redirect cycle itself
        if (redirect_i) begin
            flush_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FW'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            flush_s = flush_s;
        end
    end

    // Scoreboard and pending-count next state; same-register clear+set leaves the bit set
    always_comb begin
        inc_s     = issue_s & tracked_s;
        busy_d    = (busy_eff_s | (inc_s ? rd_onehot_s : 32'd0)) & ~32'd1;
        pending_d = pending_q + CW'(inc_s) - CW'(wb_clear_s);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            busy_q    <= 32'd0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign issue_o       = issue_s & ~rst_i;
    assign id_stall_o    = stall_s & ~rst_i;
    assign id_flush_o    = flush_s & ~rst_i;
    assign busy_o        = rst_i ? 32'd0 : busy_q;
    assign pending_cnt_o = rst_i ? '0 : pending_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl (MAX_PENDING=4, FLUSH_CYCLES=2).
module tb_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_uses_rs1_i, id_uses_rs2_i, id_reg_write_i, id_mem_to_reg_i;
    logic        ex_ready_i, redirect_i, wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic        issue_o, id_stall_o, id_flush_o;
    logic [31:0] busy_o;
    logic [2:0]  pending_cnt_o;

    int checks = 0;
    int errors = 0;

    issue_ctrl #(.MAX_PENDING(4), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .ex_ready_i(ex_ready_i), .redirect_i(redirect_i), .wb_valid_i(wb_valid_i),
        .wb_rd_addr_i(wb_rd_addr_i), .issue_o(issue_o), .id_stall_o(id_stall_o),
        .id_flush_o(id_flush_o), .busy_o(busy_o), .pending_cnt_o(pending_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 1'b0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rd_addr_i = 5'd0;
        id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; id_reg_write_i = 1'b0;
        id_mem_to_reg_i = 1'b0; redirect_i = 1'b0; wb_valid_i = 1'b0; wb_rd_addr_i = 5'd0;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        id_valid_i = 1'b1; id_rd_addr_i = rd; id_reg_write_i = 1'b1; id_mem_to_reg_i = 1'b1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        idle();
        id_valid_i = 1'b1; id_rd_addr_i = rd; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_uses_rs1_i = 1'b1; id_uses_rs2_i = 1'b1; id_reg_write_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        alu(5'd1, 5'd2, 5'd3);
        ex_ready_i = 1'b1; redirect_i = 1'b1;
        tick(); tick();
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o, id_flush_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 000", {issue_o, id_stall_o, id_flush_o});
        end
        checks++;
        if (busy_o !== 32'd0 || pending_cnt_o !== 3'd0) begin
            errors++; $display("FAIL reset_state: busy %h cnt %0d exp 0 0", busy_o, pending_cnt_o);
        end
        tick();
        idle();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_raw();
        load(5'd5);
        @(negedge clk_i);
        checks++;
        if (issue_o !== 1'b1) begin errors++; $display("FAIL raw_ld_issue: got %b exp 1", issue_o); end
        tick();
        alu(5'd6, 5'd5, 5'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if ({issue_o, id_stall_o} !== 2'b01) begin
                errors++; $display("FAIL raw_stall: got %b exp 01", {issue_o, id_stall_o});
            end
            tick();
        end
        checks++;
        if (busy_o !== 32'h20 || pending_cnt_o !== 3'd1) begin
            errors++; $display("FAIL raw_busy: busy %h cnt %0d exp 20 1", busy_o, pending_cnt_o);
        end
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd5;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o} !== 2'b10) begin
            errors++; $display("FAIL raw_release: got %b exp 10", {issue_o, id_stall_o});
        end
        tick();
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'd0 || pending_cnt_o !== 3'd0) begin
            errors++; $display("FAIL raw_clear: busy %h cnt %0d exp 0 0", busy_o, pending_cnt_o);
        end
        tick();
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            load(5'(r));
            @(negedge clk_i);
            checks++;
            if (issue_o !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b exp 1", r, issue_o); end
            tick();
        end
        load(5'd7);
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o, pending_cnt_o} !== {2'b01, 3'd4}) begin
            errors++; $display("FAIL full_stall: got %b/%0d exp 01/4", {issue_o, id_stall_o}, pending_cnt_o);
        end
        tick();
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd2;
        @(negedge clk_i);
        checks++;
        if (issue_o !== 1'b1) begin errors++; $display("FAIL full_wb_issue: got %b exp 1", issue_o); end
        tick();
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'h9A || pending_cnt_o !== 3'd4) begin
            errors++; $display("FAIL full_busy: busy %h cnt %0d exp 9a 4", busy_o, pending_cnt_o);
        end
        for (int k = 0; k < 4; k++) begin
            wb_valid_i = 1'b1;
            wb_rd_addr_i = (k == 0) ? 5'd1 : (k == 1) ? 5'd3 : (k == 2) ? 5'd4 : 5'd7;
            tick();
        end
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'd0 || pending_cnt_o !== 3'd0) begin
            errors++; $display("FAIL full_drain: busy %h cnt %0d exp 0 0", busy_o, pending_cnt_o);
        end
        tick();
    endtask

    task automatic test_flush();
        alu(5'd8, 5'd9, 5'd10);
        redirect_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o, id_flush_o} !== 3'b001) begin
            errors++; $display("FAIL flush_c1: got %b exp 001", {issue_o, id_stall_o, id_flush_o});
        end
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o, id_flush_o} !== 3'b001) begin
            errors++; $display("FAIL flush_c2: got %b exp 001", {issue_o, id_stall_o, id_flush_o});
        end
        tick();
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o, id_flush_o} !== 3'b100) begin
            errors++; $display("FAIL flush_c3: got %b exp 100", {issue_o, id_stall_o, id_flush_o});
        end
        redirect_i = 1'b1;
        tick();
        @(negedge clk_i);
        checks++;
        if (id_flush_o !== 1'b1) begin errors++; $display("FAIL flush_re_c2: got %b exp 1", id_flush_o); end
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_flush_o} !== 2'b01) begin
            errors++; $display("FAIL flush_re_c3: got %b exp 01", {issue_o, id_flush_o});
        end
        tick();
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_flush_o} !== 2'b10) begin
            errors++; $display("FAIL flush_re_c4: got %b exp 10", {issue_o, id_flush_o});
        end
        tick();
        idle();
    endtask

    task automatic test_x0();
        load(5'd0);
        @(negedge clk_i);
        checks++;
        if (issue_o !== 1'b1) begin errors++; $display("FAIL x0_ld_issue: got %b exp 1", issue_o); end
        tick();
        alu(5'd1, 5'd0, 5'd0);
        @(negedge clk_i);
        checks++;
        if ({issue_o, busy_o, pending_cnt_o} !== {1'b1, 32'd0, 3'd0}) begin
            errors++; $display("FAIL x0_b2b: issue %b busy %h cnt %0d exp 1 0 0", issue_o, busy_o, pending_cnt_o);
        end
        tick();
        idle();
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd3;
        tick();
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'd0 || pending_cnt_o !== 3'd0) begin
            errors++; $display("FAIL x0_stray_wb: busy %h cnt %0d exp 0 0", busy_o, pending_cnt_o);
        end
        tick();
    endtask

    task automatic test_ex_ready();
        alu(5'd11, 5'd12, 5'd13);
        ex_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o} !== 2'b01) begin
            errors++; $display("FAIL exrdy_low: got %b exp 01", {issue_o, id_stall_o});
        end
        tick();
        ex_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({issue_o, id_stall_o} !== 2'b10) begin
            errors++; $display("FAIL exrdy_high: got %b exp 10", {issue_o, id_stall_o});
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        load(5'd9);
        tick();
        load(5'd9);
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd9;
        @(negedge clk_i);
        checks++;
        if (issue_o !== 1'b1) begin errors++; $display("FAIL b2b_issue: got %b exp 1", issue_o); end
        tick();
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'h200 || pending_cnt_o !== 3'd1) begin
            errors++; $display("FAIL b2b_busy: busy %h cnt %0d exp 200 1", busy_o, pending_cnt_o);
        end
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd9;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        load(5'd4);
        tick();
        load(5'd5);
        tick();
        idle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'h30 || pending_cnt_o !== 3'd2) begin
            errors++; $display("FAIL rmid_pre: busy %h cnt %0d exp 30 2", busy_o, pending_cnt_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd4;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 32'd0 || pending_cnt_o !== 3'd0) begin
            errors++; $display("FAIL rmid_post: busy %h cnt %0d exp 0 0", busy_o, pending_cnt_o);
        end
        tick();
        alu(5'd4, 5'd4, 5'd5);
        @(negedge clk_i);
        checks++;
        if ({issue_o, busy_o, pending_cnt_o} !== {1'b1, 32'd0, 3'd0}) begin
            errors++; $display("FAIL rmid_late_wb: issue %b busy %h cnt %0d exp 1 0 0", issue_o, busy_o, pending_cnt_o);
        end
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        ex_ready_i = 1'b1;
        test_reset();
        ex_ready_i = 1'b1;
        test_raw();
        test_full();
        test_flush();
        test_x0();
        test_ex_ready();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
